// File: rtl/msdap_ctrl_pkg.sv
// Shared MSDAP definitions: sequencer state encoding, memory sizes and address widths.
package msdap_pkg;
    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_LOAD_RJ   = 3'd1,
        ST_LOAD_COEF = 3'd2,
        ST_WORK_IDLE = 3'd3,
        ST_WORK_WR   = 3'd4,
        ST_WORK_MAC  = 3'd5,
        ST_SLEEP     = 3'd6
    } state_t;

    localparam int RJ_COUNT_DEF    = 16;
    localparam int COEF_COUNT_DEF  = 512;
    localparam int XMEM_DEPTH_DEF  = 256;
    localparam int SLEEP_ZEROS_DEF = 800;

    localparam int RJ_AW   = 4;
    localparam int COEF_AW = 9;
    localparam int XMEM_AW = 8;
    localparam int CNT_W   = 10;
endpackage

// File: rtl/msdap_ctrl_frame_detect.sv
// Host frame strobe edge detector; latches the frame word on the rising edge of inputFrame.
module msdap_frame_detect #(
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inputFrame,
    input  logic [DATA_W-1:0] data_in,
    output logic              frame_pulse,
    output logic [DATA_W-1:0] word
);
    logic prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            prev        <= 1'b0;
            frame_pulse <= 1'b0;
            word        <= '0;
        end else begin
            prev        <= inputFrame;
            frame_pulse <= inputFrame & ~prev;
            if (inputFrame && !prev)
                word <= data_in;
        end
    end
endmodule

// File: rtl/msdap_ctrl.sv
// MSDAP main sequencer: x-memory clear, rj/coef loading, per-sample MAC launch and host ack.
// Optional zero-input sleep mode is built when MSDAP_CTRL_SLEEP_EN is defined.
module msdap_ctrl
    import msdap_pkg::*;
#(
    parameter int RJ_COUNT    = RJ_COUNT_DEF,
    parameter int COEF_COUNT  = COEF_COUNT_DEF,
    parameter int XMEM_DEPTH  = XMEM_DEPTH_DEF,
    parameter int SLEEP_ZEROS = SLEEP_ZEROS_DEF,
    parameter int DATA_W      = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inputFrame,
    input  logic [DATA_W-1:0]  data_in,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic               rj_we,
    output logic [RJ_AW-1:0]   rj_addr,
    output logic               coef_we,
    output logic [COEF_AW-1:0] coef_addr,
    output logic               x_we,
    output logic [XMEM_AW-1:0] x_addr,
    output logic               mac_start,
    input  logic               mac_done,
    output logic               outputFrame,
    output logic               out_zero,
    output logic               overrun,
    output logic [2:0]         state
);
    state_t            state_r;
    logic              frame_pulse;
    logic [DATA_W-1:0] word;
    logic [CNT_W-1:0]  cnt;
    logic              pend;
`ifdef MSDAP_CTRL_SLEEP_EN
    logic [CNT_W-1:0]  zero_cnt;
`endif

    msdap_frame_detect #(.DATA_W(DATA_W)) u_detect (
        .clock       (clock),
        .reset       (reset),
        .inputFrame  (inputFrame),
        .data_in     (data_in),
        .frame_pulse (frame_pulse),
        .word        (word)
    );

    // The clear sweep writes zeros regardless of whatever word was last latched.
    assign mem_wdata = (state_r == ST_INIT) ? '0 : word;
    assign state     = state_r;
`ifndef MSDAP_CTRL_SLEEP_EN
    assign out_zero  = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_INIT;
            cnt         <= '0;
            pend        <= 1'b0;
            rj_we       <= 1'b0;
            rj_addr     <= '0;
            coef_we     <= 1'b0;
            coef_addr   <= '0;
            x_we        <= 1'b0;
            x_addr      <= '0;
            mac_start   <= 1'b0;
            outputFrame <= 1'b0;
            overrun     <= 1'b0;
`ifdef MSDAP_CTRL_SLEEP_EN
            out_zero    <= 1'b0;
            zero_cnt    <= '0;
`endif
        end else begin
            rj_we       <= 1'b0;
            coef_we     <= 1'b0;
            x_we        <= 1'b0;
            mac_start   <= 1'b0;
            outputFrame <= 1'b0;
`ifdef MSDAP_CTRL_SLEEP_EN
            out_zero    <= 1'b0;
`endif
            case (state_r)
                ST_INIT: begin
                    if (frame_pulse) overrun <= 1'b1;
                    if (cnt < CNT_W'(XMEM_DEPTH)) begin
                        x_we   <= 1'b1;
                        x_addr <= cnt[XMEM_AW-1:0];
                        cnt    <= cnt + 1'b1;
                    end else begin
                        x_addr  <= '0;
                        cnt     <= '0;
                        state_r <= ST_LOAD_RJ;
                    end
                end
                // A new strobe cannot reach us in the ack cycle, so pend and frame_pulse never collide.
                ST_LOAD_RJ: begin
                    if (pend) begin
                        pend        <= 1'b0;
                        outputFrame <= 1'b1;
                        if (cnt == CNT_W'(RJ_COUNT - 1)) begin
                            cnt     <= '0;
                            state_r <= ST_LOAD_COEF;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (frame_pulse) begin
                        rj_we   <= 1'b1;
                        rj_addr <= cnt[RJ_AW-1:0];
                        pend    <= 1'b1;
                    end
                end
                ST_LOAD_COEF: begin
                    if (pend) begin
                        pend        <= 1'b0;
                        outputFrame <= 1'b1;
                        if (cnt == CNT_W'(COEF_COUNT - 1)) begin
                            cnt     <= '0;
                            state_r <= ST_WORK_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (frame_pulse) begin
                        coef_we   <= 1'b1;
                        coef_addr <= cnt[COEF_AW-1:0];
                        pend      <= 1'b1;
                    end
                end
                // outputFrame high here means the strobe edge coincided with mac_done: drop it.
                ST_WORK_IDLE: begin
                    if (frame_pulse) begin
                        if (outputFrame) begin
                            overrun <= 1'b1;
                        end else begin
                            x_we    <= 1'b1;
                            state_r <= ST_WORK_WR;
`ifdef MSDAP_CTRL_SLEEP_EN
                            if (word != '0)
                                zero_cnt <= '0;
                            else if (zero_cnt != CNT_W'(SLEEP_ZEROS))
                                zero_cnt <= zero_cnt + 1'b1;
`endif
                        end
                    end
                end
                ST_WORK_WR: begin
                    if (frame_pulse) overrun <= 1'b1;
                    mac_start <= 1'b1;
                    state_r   <= ST_WORK_MAC;
                end
                ST_WORK_MAC: begin
                    if (frame_pulse) overrun <= 1'b1;
                    if (mac_start) x_addr <= x_addr + 1'b1;
                    if (mac_done) begin
                        outputFrame <= 1'b1;
`ifdef MSDAP_CTRL_SLEEP_EN
                        state_r <= (zero_cnt >= CNT_W'(SLEEP_ZEROS)) ? ST_SLEEP : ST_WORK_IDLE;
`else
                        state_r <= ST_WORK_IDLE;
`endif
                    end
                end
`ifdef MSDAP_CTRL_SLEEP_EN
                ST_SLEEP: begin
                    if (frame_pulse) begin
                        if (outputFrame) begin
                            overrun <= 1'b1;
                        end else if (word == '0) begin
                            out_zero    <= 1'b1;
                            outputFrame <= 1'b1;
                        end else begin
                            zero_cnt <= '0;
                            x_we     <= 1'b1;
                            state_r  <= ST_WORK_WR;
                        end
                    end
                end
`endif
                default: state_r <= ST_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_msdap_ctrl.sv
// Self-checking bench for msdap_ctrl: randomized frames against a memory/pointer reference model.
`timescale 1ns/1ps
module tb_msdap_ctrl;
    localparam int ST_INIT = 0, ST_RJ = 1, ST_COEF = 2, ST_IDLE = 3, ST_SLEEP = 6;
    localparam int N_ZERO = 800;

    logic        clock = 1'b0;
    logic        reset, inputFrame, mac_done;
    logic [15:0] data_in, mem_wdata;
    logic        rj_we, coef_we, x_we, mac_start, outputFrame, out_zero, overrun;
    logic [3:0]  rj_addr;
    logic [8:0]  coef_addr;
    logic [7:0]  x_addr;
    logic [2:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] cap_rj [16];
    logic [15:0] cap_coef [512];
    logic [15:0] cap_x [256];
    logic [15:0] exp_rj [16];
    logic [15:0] exp_coef [512];
    logic [15:0] exp_x [256];
    int ptr  = 0;
    int zrun = 0;

    msdap_ctrl dut (
        .clock(clock), .reset(reset), .inputFrame(inputFrame), .data_in(data_in),
        .mem_wdata(mem_wdata), .rj_we(rj_we), .rj_addr(rj_addr), .coef_we(coef_we),
        .coef_addr(coef_addr), .x_we(x_we), .x_addr(x_addr), .mac_start(mac_start),
        .mac_done(mac_done), .outputFrame(outputFrame), .out_zero(out_zero),
        .overrun(overrun), .state(state)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (rj_we)   cap_rj[rj_addr]     = mem_wdata;
        if (coef_we) cap_coef[coef_addr] = mem_wdata;
        if (x_we)    cap_x[x_addr]       = mem_wdata;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish, expected finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_frame(input logic [15:0] d, input bit is_coef, input int idx);
        int h;
        h = $urandom_range(1, 3);
        inputFrame = 1'b1;
        data_in    = d;
        tick();
        data_in = 16'($urandom);
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 1) begin
                check("load_we", 32'(is_coef ? coef_we : rj_we), 1);
                check("load_addr", 32'(is_coef ? 32'(coef_addr) : 32'(rj_addr)), idx);
                check("load_data", 32'(mem_wdata), 32'(d));
                check("load_ack_early", 32'(outputFrame), 0);
            end else if (k == 2) begin
                check("load_we_off", 32'(is_coef ? coef_we : rj_we), 0);
                check("load_ack", 32'(outputFrame), 1);
            end else begin
                check("load_ack_1cyc", 32'(outputFrame), 0);
            end
            if (k >= h) inputFrame = 1'b0;
        end
        if (is_coef) exp_coef[idx] = d; else exp_rj[idx] = d;
        tick();
    endtask

    task automatic work_frame(input logic [15:0] d, input int dly, input bit probe, input bit collide);
        int exp_st;
        inputFrame = 1'b1;
        data_in    = d;
        tick();
        data_in = 16'($urandom);
        tick();
        check("x_we", 32'(x_we), 1);
        check("x_addr_wr", 32'(x_addr), ptr);
        check("x_data", 32'(mem_wdata), 32'(d));
        check("mac_start_early", 32'(mac_start), 0);
        tick();
        inputFrame = 1'b0;
        check("mac_start", 32'(mac_start), 1);
        check("x_we_1cyc", 32'(x_we), 0);
        check("x_addr_mac", 32'(x_addr), ptr);
        exp_x[ptr] = d;
        zrun = (d == 16'h0) ? zrun + 1 : 0;
        for (int i = 0; i < dly; i++) begin
            if (probe && i == 1) inputFrame = 1'b1;
            if (probe && i == 2) inputFrame = 1'b0;
            tick();
            if (i == 0) begin
                check("mac_start_1cyc", 32'(mac_start), 0);
                check("x_addr_inc", 32'(x_addr), (ptr + 1) % 256);
            end
            check("busy_no_x_we", 32'(x_we), 0);
            check("busy_no_ack", 32'(outputFrame), 0);
        end
        mac_done = 1'b1;
        if (collide) begin
            inputFrame = 1'b1;
            data_in    = 16'hBEEF;
        end
        tick();
        mac_done   = 1'b0;
        inputFrame = 1'b0;
        ptr = (ptr + 1) % 256;
        check("ack", 32'(outputFrame), 1);
`ifdef MSDAP_CTRL_SLEEP_EN
        exp_st = (zrun >= N_ZERO) ? ST_SLEEP : ST_IDLE;
`else
        exp_st = ST_IDLE;
`endif
        tick();
        check("ack_1cyc", 32'(outputFrame), 0);
        check("state_after_ack", 32'(state), exp_st);
        check("no_x_we_after_ack", 32'(x_we), 0);
        if (collide) begin
            tick();
            check("collide_dropped_we", 32'(x_we), 0);
            check("collide_state", 32'(state), ST_IDLE);
            check("collide_overrun", 32'(overrun), 1);
        end
    endtask

    initial begin
        logic [15:0] d;
        reset      = 1'b1;
        inputFrame = 1'b0;
        data_in    = '0;
        mac_done   = 1'b0;
        repeat (3) tick();
        check("rst_state", 32'(state), ST_INIT);
        check("rst_x_we", 32'(x_we), 0);
        check("rst_x_addr", 32'(x_addr), 0);
        check("rst_ack", 32'(outputFrame), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_wdata", 32'(mem_wdata), 0);
        reset = 1'b0;

        for (int i = 0; i < 256; i++) begin
            tick();
            check("init_we", 32'(x_we), 1);
            check("init_addr", 32'(x_addr), i);
            check("init_data", 32'(mem_wdata), 0);
        end
        tick();
        check("init_done_we", 32'(x_we), 0);
        check("init_exit_state", 32'(state), ST_RJ);
        check("init_exit_addr", 32'(x_addr), 0);

        for (int k = 0; k < 16; k++) load_frame(16'(k + 1), 1'b0, k);
        check("rj_to_coef", 32'(state), ST_COEF);
        for (int k = 0; k < 512; k++) load_frame(16'($urandom), 1'b1, k);
        check("coef_to_work", 32'(state), ST_IDLE);
        for (int k = 0; k < 16; k++) check("rj_mem", 32'(cap_rj[k]), 32'(exp_rj[k]));
        for (int k = 0; k < 512; k++) check("coef_mem", 32'(cap_coef[k]), 32'(exp_coef[k]));

        mac_done = 1'b1;
        tick();
        mac_done = 1'b0;
        check("stray_done_no_ack", 32'(outputFrame), 0);
        check("stray_done_state", 32'(state), ST_IDLE);

        work_frame(16'h1234, 5, 1'b0, 1'b0);
        check("first_ptr", 32'(x_addr), 1);
        for (int s = 1; s < 257; s++) begin
            d = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            if (s == 10) begin
                check("overrun_before", 32'(overrun), 0);
                work_frame(d, 5, 1'b1, 1'b0);
                check("overrun_busy", 32'(overrun), 1);
            end else begin
                work_frame(d, $urandom_range(1, 6), 1'b0, 1'b0);
            end
            if (s == 255) check("x_addr_wrap", 32'(x_addr), 0);
        end
        check("x_addr_after_257", 32'(x_addr), 1);
        work_frame(16'h0042, 3, 1'b0, 1'b1);
        for (int k = 0; k < 256; k++) check("x_mem", 32'(cap_x[k]), 32'(exp_x[k]));

`ifdef MSDAP_CTRL_SLEEP_EN
        work_frame(16'h0005, 1, 1'b0, 1'b0);
        for (int z = 0; z < N_ZERO; z++) work_frame(16'h0, 1, 1'b0, 1'b0);
        check("sleep_entered", 32'(state), ST_SLEEP);
        inputFrame = 1'b1;
        data_in    = 16'h0;
        tick();
        tick();
        check("sleep_out_zero", 32'(out_zero), 1);
        check("sleep_ack", 32'(outputFrame), 1);
        check("sleep_no_we", 32'(x_we), 0);
        inputFrame = 1'b0;
        tick();
        check("sleep_no_mac", 32'(mac_start), 0);
        check("sleep_out_zero_1cyc", 32'(out_zero), 0);
        check("sleep_ack_1cyc", 32'(outputFrame), 0);
        check("sleep_stay", 32'(state), ST_SLEEP);
        work_frame(16'h0005, 2, 1'b0, 1'b0);
        check("wake_state", 32'(state), ST_IDLE);
`else
        check("no_sleep_out_zero", 32'(out_zero), 0);
`endif

        inputFrame = 1'b1;
        data_in    = 16'h7777;
        tick();
        tick();
        inputFrame = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("midrst_state", 32'(state), ST_INIT);
        check("midrst_mac_start", 32'(mac_start), 0);
        check("midrst_x_we", 32'(x_we), 0);
        check("midrst_x_addr", 32'(x_addr), 0);
        check("midrst_overrun", 32'(overrun), 0);
        check("midrst_ack", 32'(outputFrame), 0);
        check("midrst_wdata", 32'(mem_wdata), 0);
        reset    = 1'b0;
        mac_done = 1'b1;
        tick();
        mac_done = 1'b0;
        check("aborted_done_ignored", 32'(outputFrame), 0);
        check("aborted_state", 32'(state), ST_INIT);
        inputFrame = 1'b1;
        tick();
        inputFrame = 1'b0;
        tick();
        tick();
        check("init_frame_overrun", 32'(overrun), 1);
        check("init_frame_no_ack", 32'(outputFrame), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/msdap_ctrl.md
Name: msdap_ctrl

Overview:
Main sequencing FSM for the MSDAP datapath. Detects input frame strobes and latches each 16-bit word. Steers words into the rj memory, the coefficient memory or the circular sample (x) memory. Launches the MAC engine per sample, handshakes its completion, and drives outputFrame back to the host. Also manages post-reset x-memory clearing and the zero-input sleep mode.

Parameters:
RJ_COUNT, 16, number of rj words loaded after init
COEF_COUNT, 512, number of coefficient words loaded after rj
XMEM_DEPTH, 256, sample memory depth (power of two)
SLEEP_ZEROS, 800, consecutive zero samples before entering sleep
DATA_W, 16, input word width

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
inputFrame  in  1  frame strobe from host; one word per strobe
data_in  in  DATA_W  frame word, valid while inputFrame high
mem_wdata  out  DATA_W  latched frame word, shared write data for all memories
rj_we  out  1  rj memory write enable
rj_addr  out  4  rj write address
coef_we  out  1  coefficient memory write enable
coef_addr  out  9  coefficient write address
x_we  out  1  sample memory write enable
x_addr  out  8  sample write pointer / newest-sample index for MAC
mac_start  out  1  one-cycle compute launch
mac_done  in  1  one-cycle compute completion from MAC
outputFrame  out  1  one-cycle "result/ack ready" pulse to host
out_zero  out  1  host output must read zero this frame (sleep)
overrun  out  1  sticky: frame arrived while busy
state  out  3  current FSM state (debug)

Behaviour:
- Reset: synchronous, active-high. All outputs 0, state=INIT, counters 0. Reset mid-operation aborts everything, including any pending MAC handshake.
- Frame detect: register inputFrame. A frame occurs at edge E when inputFrame=1 and prev=0. data_in is latched into mem_wdata at E. A level held over several edges counts as one frame.
- States: INIT, LOAD_RJ, LOAD_COEF, WORK_IDLE, WORK_WR, WORK_MAC, SLEEP.
- INIT: sweep x_addr 0..XMEM_DEPTH-1 with x_we=1, mem_wdata=0 (XMEM_DEPTH cycles). Then go to LOAD_RJ with x_addr=0. Frames arriving during INIT are dropped and set overrun.
- LOAD_RJ: each frame gives rj_we=1 at E+1 with rj_addr=count, then outputFrame=1 at E+2. After RJ_COUNT frames, go to LOAD_COEF.
- LOAD_COEF: same timing using coef_we/coef_addr. After COEF_COUNT frames, go to WORK_IDLE.
- WORK_IDLE, on frame: WORK_WR asserts x_we at E+1. WORK_MAC asserts mac_start at E+2, with x_addr still at the written slot. x_addr increments the cycle after mac_start, wrapping XMEM_DEPTH-1 -> 0.
- WORK_MAC waits for mac_done, unbounded. If mac_done is high at edge D, outputFrame=1 for cycle D+1 only, then return to WORK_IDLE.
- mac_done outside WORK_MAC is ignored.
- Any frame in WORK_WR/WORK_MAC is dropped and sets overrun; overrun clears only on reset.
- outputFrame is always exactly one cycle wide.
- Simultaneous mac_done and a new frame edge: the frame is dropped (overrun) and the result is still acknowledged.

Optional Feature:
MSDAP_CTRL_SLEEP_EN.
- Defined:
  - zero_cnt counts consecutive zero samples in the WORK states; a nonzero sample clears it.
  - When the SLEEP_ZEROS-th zero completes its MAC, go to SLEEP.
  - In SLEEP, a zero frame does no write and no MAC; out_zero=1 and outputFrame=1 at E+1.
  - A nonzero frame wakes the block: zero_cnt=0, then normal WORK_WR timing from E.
- Undefined: no zero_cnt, SLEEP unreachable, out_zero tied 0.

Decomposition:
- Package msdap_pkg: state encoding, RJ/COEF/XMEM/SLEEP constants, address widths, shared by the MAC and memory blocks.
- Sub-module msdap_frame_detect: inputFrame edge detect plus data latch, outputs frame_pulse and word.

Test Plan:
- Reset, then idle -> x_we high 256 consecutive cycles, addresses 0..255 with data 0; state leaves INIT.
- 16 frames 0x0001..0x0010 -> rj_addr 0..15 written with those values, 16 outputFrame pulses, then LOAD_COEF.
- 512 coef frames, then sample 0x1234 -> x_we at E+1 addr 0, mac_start at E+2, mac_done 5 cycles later -> outputFrame 1 cycle after; x_addr=1.
- 257 samples -> x_addr wraps to 0 after 256th; second frame during WORK_MAC -> overrun=1, no x_we.
- With MSDAP_CTRL_SLEEP_EN: 800 zeros -> SLEEP; next zero -> out_zero=1, no mac_start; then 0x0005 -> wake, mac_start at E+2.
- Assert reset during WORK_MAC -> next cycle all outputs 0, state=INIT, overrun cleared.
